// File: rtl/rx_deserializer.sv
// rx_deserializer: assembles LSB-first serial bits into WIDTH-bit words and
// holds each completed word in a valid/ready output register. A word that
// completes while the register is still occupied is dropped and flagged by
// the sticky overrun output.
//
// Optional feature macro: RX_DESER_PARITY_EN
//   When defined, an even-parity bit follows each word and the parity_err
//   output is added. When undefined, a word is exactly WIDTH bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no partial word; the next sampled bit is bit 0
// SHIFT | partial word in progress; count holds the next bit index

module rx_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
`ifdef RX_DESER_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef RX_DESER_PARITY_EN
    // The parity bit occupies index WIDTH, so the counter runs one further.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             complete;
    logic             load;
    logic             drop;

    // Assembly state register: FSM state, bit counter and bit-placement register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: place each sampled bit at its index; flush wins over a sample.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        complete = 1'b0;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else if (serial_valid) begin
            case (state_q)
                IDLE: begin
                    shift_d[0] = serial_in;
                    count_d    = CW'(1);
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    for (int i = 1; i < WIDTH; i++) begin
                        if (count_q == CW'(i)) begin
                            shift_d[i] = serial_in;
                        end
                    end
                    if (count_q == LAST_CNT) begin
                        complete = 1'b1;
                        count_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // A finished word loads if the register is free or being drained on this edge.
    always_comb begin
        load = complete && (!data_valid || data_ready);
        drop = complete && !load;
    end

    // Output register with handshake and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef RX_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (load) begin
                data_out   <= shift_d;
                data_valid <= 1'b1;
`ifdef RX_DESER_PARITY_EN
                // On the parity edge serial_in carries the parity bit itself.
                parity_err <= ^{shift_d, serial_in};
`endif
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign busy = (state_q == SHIFT);

endmodule
